// File: rtl/parity_accum_mem_if.sv
// Request/response bundle for the banked parity store: element writes,
// row reads with a valid/ready response, and the clear control/status.
interface parity_accum_mem_if #(
    parameter int NUM_BANKS  = 4,
    parameter int LOG2_DEPTH = 8,
    parameter int PARITY_W   = 32
);
    localparam int NB_LOG2    = $clog2(NUM_BANKS);
    localparam int ROW_ADDR_W = LOG2_DEPTH - NB_LOG2;
    localparam int ROW_W      = NUM_BANKS * PARITY_W;

    logic                  wr_req_val;
    logic [LOG2_DEPTH-1:0] wr_req_addr;
    logic [PARITY_W-1:0]   wr_req_data;
    logic                  wr_req_acc;
    logic                  wr_req_rdy;

    logic                  rd_req_val;
    logic [ROW_ADDR_W-1:0] rd_req_row;
    logic                  rd_req_rdy;

    logic                  rd_resp_val;
    logic [ROW_W-1:0]      rd_resp_data;
    logic                  rd_resp_rdy;

    logic                  clr_req;
    logic                  busy;
    logic                  clr_done;

    modport master (
        output wr_req_val, wr_req_addr, wr_req_data, wr_req_acc,
        output rd_req_val, rd_req_row, rd_resp_rdy, clr_req,
        input  wr_req_rdy, rd_req_rdy, rd_resp_val, rd_resp_data,
        input  busy, clr_done
    );

    modport slave (
        input  wr_req_val, wr_req_addr, wr_req_data, wr_req_acc,
        input  rd_req_val, rd_req_row, rd_resp_rdy, clr_req,
        output wr_req_rdy, rd_req_rdy, rd_resp_val, rd_resp_data,
        output busy, clr_done
    );
endinterface

// File: rtl/parity_accum_mem.sv
// Banked parity store: interleaved element writes (overwrite or XOR
// accumulate through a two-stage read-modify-write with forwarding), full
// row reads through a 2-entry response buffer, and a whole-array clear.
//
//   state | meaning
//   IDLE  | normal operation, requests accepted
//   DRAIN | clear requested, waiting for the W1 write stage to empty
//   CLEAR | zeroing one row of every bank per cycle
module parity_accum_mem #(
    parameter int NUM_BANKS  = 4,
    parameter int LOG2_DEPTH = 8,
    parameter int PARITY_W   = 32
) (
    input logic               clk,
    input logic               rst,
    parity_accum_mem_if.slave bus
);
    localparam int NB_LOG2    = $clog2(NUM_BANKS);
    localparam int BANK_SEL_W = (NB_LOG2 > 1) ? NB_LOG2 : 1;
    localparam int ROW_ADDR_W = LOG2_DEPTH - NB_LOG2;
    localparam int ROWS       = 2 ** ROW_ADDR_W;
    localparam int ROW_W      = NUM_BANKS * PARITY_W;
    localparam logic [ROW_ADDR_W-1:0] ROW_MAX = '1;

    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

    state_t                state_q, state_d;
    logic [ROW_ADDR_W-1:0] clr_row_q;
    logic                  clr_done_q;
    logic                  rdy_en_q;

    logic                  idle_rdy, rd_fire, wr_fire, acc_fire;
    logic [BANK_SEL_W-1:0] w0_bank;
    logic [ROW_ADDR_W-1:0] w0_row;

    logic                  w1_val_q, w1_acc_q, w1_fwd_q;
    logic [BANK_SEL_W-1:0] w1_bank_q;
    logic [ROW_ADDR_W-1:0] w1_row_q;
    logic [PARITY_W-1:0]   w1_data_q, w1_fwd_data_q, w1_old, w1_wval;

    logic                  rp_val_q, rp_fwd_q;
    logic [BANK_SEL_W-1:0] rp_fwd_bank_q;
    logic [PARITY_W-1:0]   rp_fwd_data_q;
    logic [ROW_W-1:0]      row_data;

    logic [PARITY_W-1:0]   mem  [NUM_BANKS][ROWS];
    logic [PARITY_W-1:0]   rd_q [NUM_BANKS];

    logic [ROW_W-1:0]      rb_data_q [2];
    logic                  rb_head_q;
    logic [1:0]            rb_cnt_q;
    logic [1:0]            rb_pend;
    logic                  rb_pop;

    assign w0_bank = (NUM_BANKS > 1) ? bus.wr_req_addr[BANK_SEL_W-1:0] : '0;
    assign w0_row  = bus.wr_req_addr[LOG2_DEPTH-1:NB_LOG2];

    // Pops are counted so a full-speed consumer keeps reads flowing every cycle.
    assign rb_pop   = (rb_cnt_q != 2'd0) && bus.rd_resp_rdy;
    assign rb_pend  = rb_cnt_q + {1'b0, rp_val_q} - {1'b0, rb_pop};
    assign idle_rdy = rdy_en_q && (state_q == IDLE);

    assign bus.rd_req_rdy = idle_rdy && (rb_pend < 2'd2);
    assign rd_fire        = bus.rd_req_val && bus.rd_req_rdy;
    // A row read occupies every bank read port, so it beats an accumulate.
    assign bus.wr_req_rdy = idle_rdy && !(rd_fire && bus.wr_req_acc);
    assign wr_fire        = bus.wr_req_val && bus.wr_req_rdy;
    assign acc_fire       = wr_fire && bus.wr_req_acc;

    assign w1_old  = w1_fwd_q ? w1_fwd_data_q : rd_q[w1_bank_q];
    assign w1_wval = w1_acc_q ? (w1_old ^ w1_data_q) : w1_data_q;

    assign bus.busy         = (state_q != IDLE);
    assign bus.clr_done     = clr_done_q;
    assign bus.rd_resp_val  = (rb_cnt_q != 2'd0);
    assign bus.rd_resp_data = rb_data_q[rb_head_q];

    // Next-state logic for the clear sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.clr_req) state_d = DRAIN;
            DRAIN:   if (!w1_val_q) state_d = CLEAR;
            CLEAR:   if (clr_row_q == ROW_MAX) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register, clear row counter (saturating), done pulse, ready enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            clr_row_q  <= '0;
            clr_done_q <= 1'b0;
            rdy_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_done_q <= (state_q == CLEAR) && (clr_row_q == ROW_MAX);
            rdy_en_q   <= 1'b1;
            if (state_q != CLEAR) begin
                clr_row_q <= '0;
            end else if (clr_row_q != ROW_MAX) begin
                clr_row_q <= clr_row_q + 1'b1;
            end
        end
    end

    // Bank RAMs: clear or W1 write port, and registered read port shared by row reads and W0 accumulates.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (state_q == CLEAR) begin
                mem[b][clr_row_q] <= '0;
            end else if (w1_val_q && (w1_bank_q == BANK_SEL_W'(b))) begin
                mem[b][w1_row_q] <= w1_wval;
            end
            if (rd_fire) begin
                rd_q[b] <= mem[b][bus.rd_req_row];
            end else if (acc_fire && (w0_bank == BANK_SEL_W'(b))) begin
                rd_q[b] <= mem[b][w0_row];
            end
        end
    end

    // W0->W1 write stage and read stage; both capture the W1 value the RAM read misses this cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w1_val_q      <= 1'b0;
            w1_acc_q      <= 1'b0;
            w1_fwd_q      <= 1'b0;
            w1_bank_q     <= '0;
            w1_row_q      <= '0;
            w1_data_q     <= '0;
            w1_fwd_data_q <= '0;
            rp_val_q      <= 1'b0;
            rp_fwd_q      <= 1'b0;
            rp_fwd_bank_q <= '0;
            rp_fwd_data_q <= '0;
        end else begin
            w1_val_q <= wr_fire;
            if (wr_fire) begin
                w1_acc_q      <= bus.wr_req_acc;
                w1_bank_q     <= w0_bank;
                w1_row_q      <= w0_row;
                w1_data_q     <= bus.wr_req_data;
                w1_fwd_q      <= w1_val_q && (w1_bank_q == w0_bank) && (w1_row_q == w0_row);
                w1_fwd_data_q <= w1_wval;
            end
            rp_val_q <= rd_fire;
            if (rd_fire) begin
                rp_fwd_q      <= w1_val_q && (w1_row_q == bus.rd_req_row);
                rp_fwd_bank_q <= w1_bank_q;
                rp_fwd_data_q <= w1_wval;
            end
        end
    end

    // Assemble the returned row, substituting the forwarded element where needed.
    always_comb begin
        row_data = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            row_data[b*PARITY_W +: PARITY_W] =
                (rp_fwd_q && (rp_fwd_bank_q == BANK_SEL_W'(b))) ? rp_fwd_data_q : rd_q[b];
        end
    end

    // Two-entry response FIFO; it keeps draining while a clear runs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rb_data_q[0] <= '0;
            rb_data_q[1] <= '0;
            rb_head_q    <= 1'b0;
            rb_cnt_q     <= 2'd0;
        end else begin
            if (rp_val_q) begin
                rb_data_q[rb_head_q ^ rb_cnt_q[0]] <= row_data;
            end
            if (rb_pop) begin
                rb_head_q <= ~rb_head_q;
            end
            rb_cnt_q <= rb_cnt_q + {1'b0, rp_val_q} - {1'b0, rb_pop};
        end
    end
endmodule

// File: tb/tb_parity_accum_mem.sv
// Self-checking bench for parity_accum_mem with 4 banks of 8-bit elements
// and 16 elements. Reference model: a flat element array updated in accept
// order; a read returns the row as it stood before any write accepted in
// the same cycle.
module tb_parity_accum_mem;
    localparam int NB  = 4;
    localparam int L2D = 4;
    localparam int PW  = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [PW-1:0]    model_mem [16];
    logic [NB*PW-1:0] exp_q [$];
    logic [NB*PW-1:0] got_q [$];

    parity_accum_mem_if #(.NUM_BANKS(NB), .LOG2_DEPTH(L2D), .PARITY_W(PW)) bus ();

    parity_accum_mem #(.NUM_BANKS(NB), .LOG2_DEPTH(L2D), .PARITY_W(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time expired, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    // Reference model and response capture, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.clr_done) begin
                for (int i = 0; i < 16; i++) model_mem[i] = '0;
            end
            if (bus.rd_req_val && bus.rd_req_rdy) begin
                logic [NB*PW-1:0] r;
                for (int b = 0; b < NB; b++) r[b*PW +: PW] = model_mem[int'(bus.rd_req_row) * NB + b];
                exp_q.push_back(r);
            end
            if (bus.wr_req_val && bus.wr_req_rdy) begin
                if (bus.wr_req_acc) model_mem[bus.wr_req_addr] = model_mem[bus.wr_req_addr] ^ bus.wr_req_data;
                else                model_mem[bus.wr_req_addr] = bus.wr_req_data;
            end
            if (bus.rd_resp_val && bus.rd_resp_rdy) got_q.push_back(bus.rd_resp_data);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_req_val  = 1'b0;
        bus.wr_req_addr = '0;
        bus.wr_req_data = '0;
        bus.wr_req_acc  = 1'b0;
        bus.rd_req_val  = 1'b0;
        bus.rd_req_row  = '0;
        bus.rd_resp_rdy = 1'b1;
        bus.clr_req     = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model_mem[i] = 'x;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic run_clear(output int nbusy, output int npulse);
        bus.clr_req = 1'b1;
        cyc();
        bus.clr_req = 1'b0;
        nbusy  = 0;
        npulse = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.busy) nbusy++;
            if (bus.clr_done) npulse++;
            cyc();
        end
    endtask

    task automatic write_elem(input int a, input logic [PW-1:0] d, input bit acc, output bit ok);
        bus.wr_req_val  = 1'b1;
        bus.wr_req_addr = L2D'(a);
        bus.wr_req_data = d;
        bus.wr_req_acc  = acc;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.wr_req_rdy) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
        if (ok) cyc();
        bus.wr_req_val = 1'b0;
    endtask

    task automatic issue_read(input int row, output bit ok);
        bus.rd_req_val = 1'b1;
        bus.rd_req_row = 2'(row);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.rd_req_rdy) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
        if (ok) cyc();
        bus.rd_req_val = 1'b0;
    endtask

    task automatic wait_resp(output logic [NB*PW-1:0] got, output logic [NB*PW-1:0] exp, output bit ok);
        ok  = 1'b0;
        got = 'x;
        exp = 'x;
        for (int i = 0; i < 30; i++) begin
            if (got_q.size() > 0 && exp_q.size() > 0) begin
                got = got_q.pop_front();
                exp = exp_q.pop_front();
                ok  = 1'b1;
                break;
            end
            cyc();
        end
    endtask

    task automatic read_and_check(input string name, input int row, input logic [NB*PW-1:0] want);
        bit ok;
        logic [NB*PW-1:0] got, exp;
        issue_read(row, ok);
        if (ok) wait_resp(got, exp, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: no response for row %0d within cycle budget", name, row);
        end else begin
            if (got !== want) begin
                errors++;
                $display("FAIL %s: row %0d data %h expected %h", name, row, got, want);
            end
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s_model: row %0d data %h model %h", name, row, got, exp);
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        model_reset();
        cyc();
        cyc();
        checks++;
        if ({bus.wr_req_rdy, bus.rd_req_rdy, bus.busy, bus.clr_done, bus.rd_resp_val} !== 5'b0 ||
            bus.rd_resp_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rdy/busy/done/val %b data %h expected all 0",
                     {bus.wr_req_rdy, bus.rd_req_rdy, bus.busy, bus.clr_done, bus.rd_resp_val}, bus.rd_resp_data);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.wr_req_rdy, bus.rd_req_rdy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_rdy_before_clock: %b expected 00", {bus.wr_req_rdy, bus.rd_req_rdy});
        end
        cyc();
        checks++;
        if ({bus.wr_req_rdy, bus.rd_req_rdy} !== 2'b11) begin
            errors++;
            $display("FAIL reset_rdy_after_clock: %b expected 11", {bus.wr_req_rdy, bus.rd_req_rdy});
        end
    endtask

    task automatic test_clear();
        int nbusy, npulse;
        run_clear(nbusy, npulse);
        checks++;
        if (nbusy != 5) begin
            errors++;
            $display("FAIL clear_busy_cycles: got %0d expected 5", nbusy);
        end
        checks++;
        if (npulse != 1) begin
            errors++;
            $display("FAIL clear_done_pulses: got %0d expected 1", npulse);
        end
        for (int r = 0; r < 4; r++) read_and_check("clear_row", r, '0);
    endtask

    task automatic test_overwrite();
        bit ok;
        bit all_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            write_elem(i, PW'((i + 1) * 17), 1'b0, ok);
            all_ok &= ok;
        end
        checks++;
        if (!all_ok) begin
            errors++;
            $display("FAIL overwrite_accept: a write was not accepted within budget");
        end
        read_and_check("overwrite_row0", 0, 32'h44332211);
    endtask

    task automatic test_accum_fwd();
        int nbusy, npulse;
        bit ok1, ok2;
        run_clear(nbusy, npulse);
        checks++;
        if (npulse != 1 || nbusy != 5) begin
            errors++;
            $display("FAIL accum_clear: busy %0d pulses %0d expected 5 and 1", nbusy, npulse);
        end
        write_elem(5, 8'h0F, 1'b1, ok1);
        write_elem(5, 8'hF0, 1'b1, ok2);
        checks++;
        if (!(ok1 && ok2)) begin
            errors++;
            $display("FAIL accum_accept: accepted %b%b expected 11", ok1, ok2);
        end
        read_and_check("accum_fwd_row1", 1, 32'h0000FF00);
    endtask

    task automatic test_read_acc_conflict();
        bit ok;
        logic [NB*PW-1:0] got, exp;
        bus.rd_req_val  = 1'b1;
        bus.rd_req_row  = 2'd1;
        bus.wr_req_val  = 1'b1;
        bus.wr_req_addr = 4'd4;
        bus.wr_req_data = 8'h5A;
        bus.wr_req_acc  = 1'b1;
        #1;
        checks++;
        if (bus.wr_req_rdy !== 1'b0 || bus.rd_req_rdy !== 1'b1) begin
            errors++;
            $display("FAIL conflict_arb: wr_rdy %b rd_rdy %b expected 0 1", bus.wr_req_rdy, bus.rd_req_rdy);
        end
        cyc();
        bus.rd_req_val = 1'b0;
        #1;
        checks++;
        if (bus.wr_req_rdy !== 1'b1) begin
            errors++;
            $display("FAIL conflict_write_next: wr_rdy %b expected 1", bus.wr_req_rdy);
        end
        cyc();
        bus.wr_req_val = 1'b0;
        wait_resp(got, exp, ok);
        checks++;
        if (!ok || got !== 32'h0000FF00 || got !== exp) begin
            errors++;
            $display("FAIL conflict_old_value: got %h model %h expected 0000ff00 (resp %b)", got, exp, ok);
        end
        read_and_check("conflict_new_value", 1, 32'h0000FF5A);
    endtask

    task automatic test_backpressure();
        bit ok;
        int accepted = 0;
        int unstable = 0;
        int rdy_high = 0;
        logic [NB*PW-1:0] held;
        write_elem(1, 8'h77, 1'b0, ok);
        write_elem(8, 8'hA5, 1'b0, ok);
        bus.rd_resp_rdy = 1'b0;
        bus.rd_req_val  = 1'b1;
        for (int i = 0; i < 10 && accepted < 2; i++) begin
            bus.rd_req_row = 2'(accepted);
            #1;
            if (bus.rd_req_rdy) accepted++;
            cyc();
        end
        checks++;
        if (accepted != 2) begin
            errors++;
            $display("FAIL backpressure_accept: accepted %0d expected 2", accepted);
        end
        bus.rd_req_row = 2'd2;
        held = bus.rd_resp_data;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (bus.rd_req_rdy) rdy_high++;
            if (!bus.rd_resp_val || bus.rd_resp_data !== held) unstable++;
            cyc();
        end
        checks++;
        if (rdy_high != 0) begin
            errors++;
            $display("FAIL backpressure_rdy: rd_req_rdy high %0d cycles expected 0", rdy_high);
        end
        checks++;
        if (unstable != 0) begin
            errors++;
            $display("FAIL backpressure_stable: data changed or dropped %0d cycles expected 0", unstable);
        end
        bus.rd_resp_rdy = 1'b1;
        #1;
        checks++;
        if (bus.rd_req_rdy !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release: rd_req_rdy %b expected 1", bus.rd_req_rdy);
        end
        cyc();
        bus.rd_req_val = 1'b0;
        for (int i = 0; i < 3; i++) begin
            logic [NB*PW-1:0] got, exp;
            wait_resp(got, exp, ok);
            checks++;
            if (!ok || got !== exp) begin
                errors++;
                $display("FAIL backpressure_order: response %0d got %h model %h (resp %b)", i, got, exp, ok);
            end
        end
    endtask

    task automatic test_random();
        int n = 0;
        bit drained = 1'b0;
        for (int i = 0; i < 400; i++) begin
            bus.wr_req_val  = ($urandom_range(0, 1) == 1);
            bus.wr_req_addr = ($urandom_range(0, 1) == 1) ? L2D'($urandom_range(4, 5)) : L2D'($urandom_range(0, 15));
            bus.wr_req_data = PW'($urandom);
            bus.wr_req_acc  = ($urandom_range(0, 1) == 1);
            bus.rd_req_val  = ($urandom_range(0, 2) == 0);
            bus.rd_req_row  = 2'($urandom_range(0, 3));
            bus.rd_resp_rdy = ($urandom_range(0, 3) != 0);
            cyc();
        end
        bus.wr_req_val  = 1'b0;
        bus.rd_req_val  = 1'b0;
        bus.rd_resp_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (!bus.rd_resp_val && got_q.size() == exp_q.size()) begin
                drained = 1'b1;
                break;
            end
        end
        checks++;
        if (!drained) begin
            errors++;
            $display("FAIL random_drain: got %0d responses, model %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [NB*PW-1:0] got, exp;
            got = got_q.pop_front();
            exp = exp_q.pop_front();
            checks++;
            n++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random_row: response %0d got %h model %h", n, got, exp);
            end
        end
        checks++;
        if (n < 20) begin
            errors++;
            $display("FAIL random_count: only %0d responses compared, expected at least 20", n);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset_mid_clear();
        int nbusy, npulse;
        int spurious = 0;
        bus.clr_req = 1'b1;
        cyc();
        bus.clr_req = 1'b0;
        cyc();
        cyc();
        cyc();
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL midclear_busy: busy %b expected 1 at clear row 2", bus.busy);
        end
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({bus.busy, bus.clr_done, bus.wr_req_rdy, bus.rd_req_rdy, bus.rd_resp_val} !== 5'b0) begin
            errors++;
            $display("FAIL midclear_async: busy/done/wrdy/rrdy/val %b expected 00000",
                     {bus.busy, bus.clr_done, bus.wr_req_rdy, bus.rd_req_rdy, bus.rd_resp_val});
        end
        cyc();
        cyc();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (bus.clr_done || bus.busy) spurious++;
            cyc();
        end
        checks++;
        if (spurious != 0) begin
            errors++;
            $display("FAIL midclear_no_done: %0d cycles with busy or clr_done expected 0", spurious);
        end
        run_clear(nbusy, npulse);
        checks++;
        if (nbusy != 5 || npulse != 1) begin
            errors++;
            $display("FAIL midclear_reclear: busy %0d pulses %0d expected 5 and 1", nbusy, npulse);
        end
        read_and_check("midclear_row2", 2, '0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_clear();
        test_overwrite();
        test_accum_fwd();
        test_read_acc_conflict();
        test_backpressure();
        test_random();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
